// File: rtl/adc_ctrl.sv
// adc_ctrl: ADC start / EOC / OE handshake initiator.
// Launches a conversion on a request or on the auto-mode period tick, waits
// for EOC to fall and rise again, reads the result with OE and presents it
// as a one-cycle-valid sample. A converter that stops responding is
// abandoned after TIMEOUT cycles in either wait state.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   req            single-cycle conversion request
//   auto_en        enables periodic conversions every SAMPLE_PERIOD cycles
//   adc_eoc        ADC end-of-conversion (1 = idle/done, 0 = converting)
//   adc_data       ADC result, captured on the last OE cycle
//   adc_start      start pulse to the ADC (START_WIDTH cycles)
//   adc_oe         output enable to the ADC (OE_WIDTH cycles)
//   sample         last captured code
//   sample_valid   one-cycle strobe when sample updates
//   busy           high whenever the controller is not IDLE
//   timeout_err    one-cycle strobe when a wait state is abandoned
//
// state     | meaning
// IDLE      | waiting for req, pending request or auto tick
// START     | adc_start high for START_WIDTH cycles
// WAIT_LOW  | waiting for EOC to fall (conversion running)
// WAIT_HIGH | waiting for EOC to rise (conversion done)
// READ      | adc_oe high for OE_WIDTH cycles, capture on the last one
// RELEASE   | adc_oe low for one cycle before returning to IDLE
module adc_ctrl #(
  parameter int START_WIDTH   = 2,
  parameter int OE_WIDTH      = 3,
  parameter int TIMEOUT       = 1023,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        auto_en,
  input  logic        adc_eoc,
  input  logic [11:0] adc_data,
  output logic        adc_start,
  output logic        adc_oe,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    READ      = 3'd4,
    RELEASE   = 3'd5
  } state_t;

  // Terminal counts: the phase counter holds the number of cycles already
  // spent in the current state, so the last cycle is at count N-1.
  localparam logic [15:0] START_LAST = 16'(START_WIDTH - 1);
  localparam logic [15:0] OE_LAST    = 16'(OE_WIDTH - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
  localparam logic [15:0] PER_LAST   = 16'(SAMPLE_PERIOD - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] per_q, per_d;
  logic        pend_q, pend_d;
  logic        start_q, start_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        sv_q, sv_d;
  logic        to_q, to_d;
  logic [11:0] sample_q, sample_d;
  logic        tick, trig, cap, abort;

  assign tick = auto_en && (per_q == PER_LAST);
  assign trig = req || pend_q || tick;

  // State register, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      per_q    <= '0;
      pend_q   <= 1'b0;
      start_q  <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      sv_q     <= 1'b0;
      to_q     <= 1'b0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      pend_q   <= pend_d;
      start_q  <= start_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      sv_q     <= sv_d;
      to_q     <= to_d;
      sample_q <= sample_d;
    end
  end

  // Next-state logic. EOC is only looked at in the two wait states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    pend_d  = pend_q;
    cap     = 1'b0;
    abort   = 1'b0;

    if (!auto_en || per_q == PER_LAST) per_d = '0;
    else                               per_d = per_q + 16'd1;

    // One-deep queue: a second request while pending is simply absorbed.
    if (state_q != IDLE && (req || tick)) pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (trig) begin
          state_d = START;
          pend_d  = 1'b0;
        end
      end
      START: begin
        if (cnt_q == START_LAST) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (!adc_eoc) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = RELEASE;
          abort   = 1'b1;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (adc_eoc) begin
          state_d = READ;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = RELEASE;
          abort   = 1'b1;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (cnt_q == OE_LAST) begin
          state_d = RELEASE;
          cap     = 1'b1;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same
  // edge as the state and stay glitch-free.
  always_comb begin
    start_d  = (state_d == START);
    oe_d     = (state_d == READ);
    busy_d   = (state_d != IDLE);
    sv_d     = cap;
    to_d     = abort;
    sample_d = cap ? adc_data : sample_q;
  end

  assign adc_start    = start_q;
  assign adc_oe       = oe_q;
  assign sample       = sample_q;
  assign sample_valid = sv_q;
  assign busy         = busy_q;
  assign timeout_err  = to_q;

endmodule

// File: tb/tb_adc_ctrl.sv
module tb_adc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        auto_en;
  logic        adc_eoc = 1'b1;
  logic [11:0] adc_data = 12'h000;
  logic        adc_start, adc_oe, sample_valid, busy, timeout_err;
  logic [11:0] sample;

  // Second instance with a short timeout; its EOC/data are driven directly.
  logic        req_t, eoc_t, auto_t;
  logic [11:0] data_t;
  logic        adc_start_t, adc_oe_t, sample_valid_t, busy_t, timeout_err_t;
  logic [11:0] sample_t;

  adc_ctrl #(.START_WIDTH(2), .OE_WIDTH(3), .TIMEOUT(1023), .SAMPLE_PERIOD(1000)) u_dut (
    .clk(clk), .rst(rst), .req(req), .auto_en(auto_en), .adc_eoc(adc_eoc),
    .adc_data(adc_data), .adc_start(adc_start), .adc_oe(adc_oe), .sample(sample),
    .sample_valid(sample_valid), .busy(busy), .timeout_err(timeout_err)
  );

  adc_ctrl #(.START_WIDTH(2), .OE_WIDTH(3), .TIMEOUT(50), .SAMPLE_PERIOD(1000)) u_dut_to (
    .clk(clk), .rst(rst), .req(req_t), .auto_en(auto_t), .adc_eoc(eoc_t),
    .adc_data(data_t), .adc_start(adc_start_t), .adc_oe(adc_oe_t), .sample(sample_t),
    .sample_valid(sample_valid_t), .busy(busy_t), .timeout_err(timeout_err_t)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ADC model: EOC drops one cycle after start falls, stays low for conv_len
  // cycles; data is only valid from the cycle after OE is first seen high.
  int          conv_len = 300;
  logic [31:0] vin = 32'h0;
  logic        m_start_p = 1'b0, m_oe_p = 1'b0;
  bit          m_arm = 1'b0;
  int          m_cnt = 0;

  always @(negedge clk) begin
    if (m_arm) begin
      adc_eoc = 1'b0;
      m_cnt   = conv_len;
      m_arm   = 1'b0;
    end else if (!adc_eoc) begin
      m_cnt--;
      if (m_cnt <= 0) adc_eoc = 1'b1;
    end
    if (m_start_p && !adc_start) m_arm = 1'b1;
    adc_data  = (adc_oe && m_oe_p) ? vin[31:20] : ~vin[31:20];
    m_start_p = adc_start;
    m_oe_p    = adc_oe;
  end

  // Output monitor: records observations; all comparisons happen in the
  // main sequence.
  int          start_times[$];
  int          start_w[$];
  int          oe_w[$];
  int          sv_times[$];
  logic [11:0] sv_data[$];
  bit          sv_ok[$];
  int          n_to = 0;
  bit          overlap = 1'b0;
  logic        start_p = 1'b0, oe_p = 1'b0;
  int          start_rise_c = 0, oe_rise_c = 0;

  always @(negedge clk) begin
    if (rst) begin
      start_p = 1'b0;
      oe_p    = 1'b0;
    end else begin
      if (adc_start && !start_p) begin
        start_rise_c = cyc;
        start_times.push_back(cyc);
      end
      if (!adc_start && start_p) start_w.push_back(cyc - start_rise_c);
      if (adc_oe && !oe_p) oe_rise_c = cyc;
      if (!adc_oe && oe_p) oe_w.push_back(cyc - oe_rise_c);
      if ((adc_start && adc_oe) || (adc_start_t && adc_oe_t)) overlap = 1'b1;
      if (sample_valid) begin
        sv_times.push_back(cyc);
        sv_data.push_back(sample);
        sv_ok.push_back({adc_oe, oe_p} == 2'b01);
      end
      if (timeout_err) n_to++;
      start_p = adc_start;
      oe_p    = adc_oe;
    end
  end

  logic [11:0] exp_q[$];
  int sw_rd = 0, ow_rd = 0, sv_rd = 0;
  int st_base = 0, sv_base = 0;

  task automatic mark();
    st_base = start_times.size();
    sv_base = sv_times.size();
  endtask

  // Scoreboard drain: every sample_valid pops one expected code.
  task automatic drain(input string tag);
    while (sw_rd < start_w.size()) begin
      chk({tag, "_start_width"}, 32'(start_w[sw_rd]), 32'd2);
      sw_rd++;
    end
    while (ow_rd < oe_w.size()) begin
      chk({tag, "_oe_width"}, 32'(oe_w[ow_rd]), 32'd3);
      ow_rd++;
    end
    while (sv_rd < sv_data.size()) begin
      chk({tag, "_sv_phase"}, 32'(sv_ok[sv_rd]), 32'd1);
      chk({tag, "_sv_expected"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk({tag, "_sample"}, 32'(sv_data[sv_rd]), 32'(exp_q.pop_front()));
      sv_rd++;
    end
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_req();
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_starts(input string tag, input int n, input int max);
    int k = 0;
    while (start_times.size() - st_base < n && k < max) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_starts_seen"}, 32'(start_times.size() - st_base), 32'(n));
  endtask

  task automatic run_timeout(input string tag, input bit stuck_low);
    int entry_c = 0, to_c = 0, pulses = 0;
    bit oe_seen = 1'b0, sv_seen = 1'b0;
    eoc_t = 1'b1;
    @(negedge clk) req_t = 1'b1;
    @(negedge clk) req_t = 1'b0;
    for (int i = 0; i < 10 && adc_start_t !== 1'b0; i++) @(negedge clk);
    entry_c = cyc;
    if (stuck_low) begin
      eoc_t   = 1'b0;
      entry_c = cyc + 1;
    end
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (timeout_err_t) begin
        pulses++;
        to_c = cyc;
      end
      oe_seen |= adc_oe_t;
      sv_seen |= sample_valid_t;
    end
    chk({tag, "_delay"}, 32'(to_c - entry_c), 32'd50);
    chk({tag, "_pulses"}, 32'(pulses), 32'd1);
    chk({tag, "_oe_seen"}, 32'(oe_seen), 32'd0);
    chk({tag, "_sv_seen"}, 32'(sv_seen), 32'd0);
    chk({tag, "_sample_kept"}, 32'(sample_t), 32'h3C3);
    chk({tag, "_idle"}, 32'(busy_t), 32'd0);
    eoc_t = 1'b1;
  endtask

  initial begin
    int c_req;
    rst = 1'b1; req = 1'b0; auto_en = 1'b0;
    req_t = 1'b0; eoc_t = 1'b1; auto_t = 1'b0; data_t = 12'h000;
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(adc_start), 32'd0);
    chk("rst_oe", 32'(adc_oe), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_sv", 32'(sample_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    rst = 1'b0;

    // Single request, 300-cycle conversion.
    mark();
    conv_len = 300; vin = 32'hABC00000;
    exp_q.push_back(12'hABC);
    pulse_req();
    chk("single_busy_n1", 32'(busy), 32'd1);
    chk("single_start_n1", 32'(adc_start), 32'd1);
    wait_idle("single", 1000);
    chk("single_starts", 32'(start_times.size() - st_base), 32'd1);
    chk("single_svs", 32'(sv_times.size() - sv_base), 32'd1);
    chk("single_sample_out", 32'(sample), 32'hABC);
    drain("single");

    // Queued request during WAIT_HIGH, third request dropped.
    mark();
    vin = 32'h12300000;
    exp_q.push_back(12'h123);
    exp_q.push_back(12'h123);
    pulse_req();
    for (int i = 0; i < 400 && adc_eoc; i++) @(negedge clk);
    chk("queued_converting", 32'(adc_eoc), 32'd0);
    repeat (5) @(negedge clk);
    pulse_req();
    repeat (20) @(negedge clk);
    pulse_req();
    wait_starts("queued", 2, 1500);
    wait_idle("queued", 1000);
    repeat (500) @(negedge clk);
    chk("queued_starts", 32'(start_times.size() - st_base), 32'd2);
    chk("queued_svs", 32'(sv_times.size() - sv_base), 32'd2);
    if (start_times.size() - st_base >= 2 && sv_times.size() - sv_base >= 1)
      chk("queued_gap", 32'(start_times[st_base + 1] - sv_times[sv_base]), 32'd2);
    drain("queued");

    // Auto mode, start-to-start interval.
    mark();
    conv_len = 100; vin = 32'h7FF00000;
    repeat (3) exp_q.push_back(12'h7FF);
    @(negedge clk) auto_en = 1'b1;
    wait_starts("auto", 3, 3500);
    auto_en = 1'b0;
    if (start_times.size() - st_base >= 3) begin
      chk("auto_period_1", 32'(start_times[st_base + 1] - start_times[st_base]), 32'd1000);
      chk("auto_period_2", 32'(start_times[st_base + 2] - start_times[st_base + 1]), 32'd1000);
    end
    wait_idle("auto", 500);
    repeat (2500) @(negedge clk);
    chk("auto_stopped", 32'(start_times.size() - st_base), 32'd3);
    drain("auto");

    // req coincident with an auto tick.
    mark();
    exp_q.push_back(12'h7FF);
    @(negedge clk) auto_en = 1'b1;
    repeat (999) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0; auto_en = 1'b0;
    c_req = cyc;
    chk("simul_pending", 32'(u_dut.pend_q), 32'd0);
    wait_idle("simul", 1000);
    repeat (400) @(negedge clk);
    chk("simul_starts", 32'(start_times.size() - st_base), 32'd1);
    if (start_times.size() - st_base >= 1)
      chk("simul_start_time", 32'(start_times[st_base]), 32'(c_req));
    drain("simul");

    // Reset during READ.
    mark();
    conv_len = 300; vin = 32'h55500000;
    pulse_req();
    for (int i = 0; i < 600 && adc_oe !== 1'b1; i++) @(negedge clk);
    chk("rstmid_in_read", 32'(adc_oe), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_oe", 32'(adc_oe), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_start", 32'(adc_start), 32'd0);
    chk("rstmid_sample", 32'(sample), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vin = 32'h9AB00000;
    exp_q.push_back(12'h9AB);
    pulse_req();
    wait_idle("rstmid_after", 1000);
    chk("rstmid_after_sample", 32'(sample), 32'h9AB);
    drain("rstmid");

    // Timeouts on the short-timeout instance, after one good conversion.
    @(negedge clk) req_t = 1'b1;
    @(negedge clk) req_t = 1'b0;
    repeat (5) @(negedge clk);
    eoc_t = 1'b0;
    repeat (5) @(negedge clk);
    data_t = 12'h3C3; eoc_t = 1'b1;
    for (int i = 0; i < 50 && busy_t !== 1'b0; i++) @(negedge clk);
    chk("to_prep_idle", 32'(busy_t), 32'd0);
    chk("to_prep_sample", 32'(sample_t), 32'h3C3);
    data_t = 12'h111;
    run_timeout("to_wait_low", 1'b0);
    run_timeout("to_wait_high", 1'b1);

    chk("main_no_timeout", 32'(n_to), 32'd0);
    chk("no_start_oe_overlap", 32'(overlap), 32'd0);
    drain("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_ctrl.md
# adc_ctrl

Initiator for the ADC start/EOC/OE conversion handshake. On a software request, or periodically in auto mode, it pulses start to the ADC, tracks EOC through the conversion, drives OE to read the result and presents the captured 12-bit code as a one-cycle-valid sample. It sits between the ADC and the PID loop's measurement input, and flags a stalled converter with a timeout.

## Interface
- START_WIDTH, 2: cycles adc_start is held high (≥1).
- OE_WIDTH, 3: cycles adc_oe is held high (≥2); data is captured on the last one.
- TIMEOUT, 1023: maximum cycles spent in a wait state before abort (≥1, fits 16 bits).
- SAMPLE_PERIOD, 1000: auto-mode start-to-start interval in cycles (≥1, fits 16 bits).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  single-cycle conversion request.
- auto_en  in  1  enables periodic conversions.
- adc_eoc  in  1  ADC end-of-conversion: high = idle/done, low = converting.
- adc_data  in  12  ADC result; valid from the cycle after OE is first seen high.
- adc_start  out  1  start to the ADC.
- adc_oe  out  1  output enable to the ADC.
- sample  out  12  last captured code.
- sample_valid  out  1  one-cycle strobe when sample updates.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle strobe on wait-state abort.

## Operation
- All outputs are registered. Reset values: adc_start=0, adc_oe=0, sample=0, sample_valid=0, busy=0, timeout_err=0. State is IDLE, all counters are 0 and pending is 0.
- Trigger: the `trig` condition is req, OR pending, OR an auto tick.
  - Auto tick: the period counter reaches SAMPLE_PERIOD-1 while auto_en=1. The counter runs free while auto_en=1 and is cleared to 0 while auto_en=0.
  - req while busy sets the one-deep pending flag. Further requests while pending=1 are dropped. Pending is cleared when a conversion starts.
  - An auto tick while busy also sets pending.
  - Simultaneous req and auto tick produce one conversion.
- States:
  - IDLE: on trig → START.
  - START: adc_start=1 for START_WIDTH cycles → WAIT_LOW.
  - WAIT_LOW: wait for adc_eoc==0 → WAIT_HIGH.
  - WAIT_HIGH: wait for adc_eoc==1 → READ.
  - READ: adc_oe=1 for OE_WIDTH cycles. On the clock edge ending the last READ cycle, sample<=adc_data and sample_valid<=1 → RELEASE.
  - RELEASE: adc_oe=0 for exactly 1 cycle → IDLE.
- Timeout:
  - The wait counter clears on entry to WAIT_LOW and on entry to WAIT_HIGH.
  - If it reaches TIMEOUT without the awaited EOC level, timeout_err pulses, sample is unchanged, no sample_valid is issued, and the state goes to RELEASE.
- adc_eoc is treated as X-tolerant in IDLE and START: it is not evaluated there.
- Reset mid-operation drops adc_start and adc_oe immediately (asynchronously) and discards any pending request.

## Timing
- req high at edge N (IDLE) → adc_start=1 during cycles N+1…N+START_WIDTH, busy=1 from N+1.
- adc_start falls at N+START_WIDTH+1; the ADC drops EOC one cycle later.
- EOC rising sampled at edge M (WAIT_HIGH) → adc_oe=1 for cycles M+1…M+OE_WIDTH. sample and sample_valid are valid in cycle M+OE_WIDTH+1 (RELEASE, adc_oe=0).
- Back in IDLE at M+OE_WIDTH+2. A pending trigger raises adc_start on the following cycle.
- Minimum IDLE dwell is 1 cycle. adc_start and adc_oe are never high together.
- Overhead beyond the conversion time: START_WIDTH + 1 (EOC fall detect) + 1 (EOC rise detect) + OE_WIDTH + 2 cycles.

## Test plan
- Single request: ADC model with 300-cycle conversion and input 0xABC00000, req pulse → adc_start high for exactly 2 cycles, then adc_oe high for 3 cycles; sample=0xABC with one sample_valid pulse; busy then returns to 0; no timeout_err.
- Queued request: req, then req again during WAIT_HIGH, then a third req before completion → exactly two conversions, back-to-back with 1 idle cycle between; the third req is dropped.
- Auto mode: auto_en=1, SAMPLE_PERIOD=1000, ADC conversion shorter than the period → adc_start rising edges are exactly 1000 cycles apart; auto_en=0 → no further starts.
- Timeout: EOC held high (model never converts), TIMEOUT=50 → timeout_err pulses once, exactly 50 cycles after entering WAIT_LOW; adc_oe stays 0, sample keeps its prior value and no sample_valid is issued. Repeat with EOC stuck low for WAIT_HIGH.
- Reset mid-conversion: assert rst during READ with adc_oe=1 → adc_oe and busy go to 0 without waiting for a clock edge, and sample resets to 0; after release, a new req completes normally.
- Simultaneous events: req coincident with an auto tick in IDLE → one conversion, pending stays 0.
